// File: rtl/ramb16_port_arbiter.sv
// ---------------------------------------------------------------------------
// ramb16_port_arbiter
//
// Shares port A of a 512x32 dual-port block RAM (write_first) between two
// single-beat requesters. Arbitration is round-robin on ties. A beat with
// last = 0 locks the port to its requester until that requester's last beat
// is accepted. Every accepted beat, read or write, returns exactly one
// response two cycles later on the response port of the requester that
// issued it.
//
// Ports
//   CLK, resetn                 clock (rising edge), synchronous active-low reset
//   reqN_valid/ready            request handshake, beat accepted when both high
//   reqN_write/last/addr/data   beat attributes (data ignored for reads)
//   respN_valid/data            response beat, no backpressure
//   ram_en/we/addr/di           registered RAM port A controls
//   ram_ssr, ram_dip            tied low
//   ram_do                      RAM port A read data (1-cycle registered in RAM)
// ---------------------------------------------------------------------------
module ramb16_port_arbiter #(
    parameter int ADDR_BITS = 9,
    parameter int DATA_BITS = 32
) (
    input  logic                 CLK,
    input  logic                 resetn,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_write,
    input  logic                 req0_last,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_data,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_write,
    input  logic                 req1_last,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_data,

    output logic                 resp0_valid,
    output logic [DATA_BITS-1:0] resp0_data,
    output logic                 resp1_valid,
    output logic [DATA_BITS-1:0] resp1_data,

    output logic                 ram_en,
    output logic                 ram_we,
    output logic                 ram_ssr,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_di,
    output logic [3:0]           ram_dip,
    input  logic [DATA_BITS-1:0] ram_do
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   prio_q, prio_d;

    // Requester-indexed views of the flat ports.
    logic [1:0]           req_valid;
    logic [1:0]           req_write;
    logic [1:0]           req_last;
    logic [ADDR_BITS-1:0] req_addr [2];
    logic [DATA_BITS-1:0] req_data [2];
    logic [1:0]           ready;
    logic [1:0]           accept;
    logic                 any_accept;
    logic                 grant_id;

    // Stage 1: RAM command registers (plus the id of the beat they carry).
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_BITS-1:0] ram_di_q, ram_di_d;
    logic                 tag1_q, tag1_d;

    // Stage 2: response valid/id, aligned with ram_do.
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_tag_q, rsp_tag_d;

    logic [1:0]           resp_valid_vec;
    logic [DATA_BITS-1:0] resp_data_arr [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign req_write   = {req1_write, req0_write};
    assign req_last    = {req1_last, req0_last};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // Ready depends only on state, prio and the two valids. It is forced low
    // while resetn is low so nothing is accepted in a reset cycle.
    always_comb begin
        ready = 2'b00;
        if (resetn) begin
            case (state_q)
                ST_IDLE: begin
                    if (&req_valid) begin
                        ready[prio_q] = 1'b1;
                    end else begin
                        ready = req_valid;
                    end
                end
                // A locked owner stays ready even with valid low, so a stalled
                // burst keeps the port until its last beat arrives.
                ST_OWN0: ready = 2'b01;
                ST_OWN1: ready = 2'b10;
                default: ready = 2'b00;
            endcase
        end
    end

    assign accept     = req_valid & ready;
    assign any_accept = |accept;
    // At most one ready is high, so accept[1] alone identifies the winner.
    assign grant_id   = accept[1];

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (any_accept) begin
            if (req_last[grant_id]) begin
                state_d = ST_IDLE;
                prio_d  = ~grant_id;
            end else begin
                state_d = grant_id ? ST_OWN1 : ST_OWN0;
            end
        end
    end

    always_comb begin
        ram_en_d    = any_accept;
        ram_we_d    = any_accept & req_write[grant_id];
        // Address and data hold their previous value on idle cycles.
        ram_addr_d  = any_accept ? req_addr[grant_id] : ram_addr_q;
        ram_di_d    = any_accept ? req_data[grant_id] : ram_di_q;
        tag1_d      = any_accept ? grant_id : tag1_q;
        rsp_valid_d = ram_en_q;
        rsp_tag_d   = tag1_q;
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_di_q    <= '0;
            tag1_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_di_q    <= ram_di_d;
            tag1_q      <= tag1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    // Steer the RAM output to the requester that owns the stage-2 beat.
    // Response data is zero whenever that port has no response.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign resp_valid_vec[gi] = rsp_valid_q && (rsp_tag_q == 1'(gi));
            assign resp_data_arr[gi]  = resp_valid_vec[gi] ? ram_do : '0;
        end
    endgenerate

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign resp0_valid = resp_valid_vec[0];
    assign resp1_valid = resp_valid_vec[1];
    assign resp0_data  = resp_data_arr[0];
    assign resp1_data  = resp_data_arr[1];

    assign ram_en   = ram_en_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;
    assign ram_ssr  = 1'b0;
    assign ram_dip  = 4'b0000;

endmodule
